eth_tx_arbiter: RTL and testbench

Frame-granular arbiter that shares the Ethernet MAC transmit AXI-stream (32-bit `tx_axis_*`) between two packet sources: source 0 is the RVVI packetizer, source 1 is a secondary host/debug frame generator. It grants one source for a whole frame (until `tlast`), enforces a programmable idle gap between frames and truncates runaway frames. It also exposes grant and status for the testbench and FPGA debug. It sits between the packetizer outputs and `eth_mac_mii_fifo`.

---
 rtl/eth_tx_arbiter.sv | 177 +++++++++++++++++
 tb/tb_eth_tx_arbiter.sv | 460 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_arbiter.sv
// eth_tx_arbiter
// Frame-granular two-source arbiter for the Ethernet MAC transmit AXI-stream.
// Source 0 is the RVVI packetizer and source 1 is a host/debug frame generator.
// One source owns the output for a whole frame, which lasts until tlast.
// After each frame a programmable idle gap is forced. A frame that runs past
// MAX_FRAME_WORDS beats is cut short: m_tlast is forced on the last allowed
// beat, and the rest of the source frame is accepted and dropped.
//
// Ports:
//   m_axi_aclk, m_axi_aresetn : clock and asynchronous active-low reset
//   cfg_fixed_prio            : 1 = source 0 wins ties, 0 = round-robin
//   s0_* / s1_*               : AXI-stream slave inputs from the two sources
//   m_*                       : AXI-stream master output towards the MAC
//   grant                     : one-hot current owner (00 = none)
//   frame_count               : frames completed on m_* (wraps)
//   overlength                : sticky flag, set when any frame is truncated
module eth_tx_arbiter #(
  parameter int DATA_WIDTH      = 32,
  parameter int KEEP_WIDTH      = DATA_WIDTH / 8,
  parameter int FRAME_GAP       = 2,
  parameter int MAX_FRAME_WORDS = 512
) (
  input  logic                  m_axi_aclk,
  input  logic                  m_axi_aresetn,
  input  logic                  cfg_fixed_prio,
  input  logic [DATA_WIDTH-1:0] s0_tdata,
  input  logic [KEEP_WIDTH-1:0] s0_tkeep,
  input  logic                  s0_tvalid,
  input  logic                  s0_tlast,
  output logic                  s0_tready,
  input  logic [DATA_WIDTH-1:0] s1_tdata,
  input  logic [KEEP_WIDTH-1:0] s1_tkeep,
  input  logic                  s1_tvalid,
  input  logic                  s1_tlast,
  output logic                  s1_tready,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [KEEP_WIDTH-1:0] m_tkeep,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  input  logic                  m_tready,
  output logic [1:0]            grant,
  output logic [31:0]           frame_count,
  output logic                  overlength
);

  localparam int WC_W  = $clog2(MAX_FRAME_WORDS + 1);
  localparam int GAP_W = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD  = (FRAME_GAP > 0) ? GAP_W'(FRAME_GAP - 1) : '0;
  localparam logic [WC_W-1:0]  LAST_BEAT = WC_W'(MAX_FRAME_WORDS - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DRAIN, GAP} state_t;

  state_t           state;
  logic             owner;        // index of the granted source, meaningful while grant != 0
  logic             last_served;  // index of the source whose frame finished most recently
  logic [WC_W-1:0]  word_cnt;     // beats already passed in the current frame
  logic [GAP_W-1:0] gap_cnt;

  logic [DATA_WIDTH-1:0] sel_tdata;
  logic [KEEP_WIDTH-1:0] sel_tkeep;
  logic                  sel_tvalid;
  logic                  sel_tlast;
  logic                  trunc_beat;
  logic                  out_beat;
  logic                  pick_s1;

  assign sel_tdata  = owner ? s1_tdata  : s0_tdata;
  assign sel_tkeep  = owner ? s1_tkeep  : s0_tkeep;
  assign sel_tvalid = owner ? s1_tvalid : s0_tvalid;
  assign sel_tlast  = owner ? s1_tlast  : s0_tlast;

  // The current beat is the last one allowed for this frame.
  assign trunc_beat = (word_cnt == LAST_BEAT);
  assign out_beat   = (state == BUSY) && sel_tvalid && m_tready;

  // Grant decision made in IDLE. On a tie, round-robin gives the grant to
  // the source that was not served last.
  always_comb begin
    pick_s1 = 1'b0;
    if (s0_tvalid && s1_tvalid) begin
      pick_s1 = cfg_fixed_prio ? 1'b0 : ~last_served;
    end else begin
      pick_s1 = s1_tvalid;
    end
  end

  // Zero-latency pass-through while BUSY. DRAIN swallows the tail of a
  // truncated frame, so the owner sees ready high but m_tvalid stays low.
  always_comb begin
    m_tdata   = sel_tdata;
    m_tkeep   = sel_tkeep;
    m_tvalid  = 1'b0;
    m_tlast   = 1'b0;
    s0_tready = 1'b0;
    s1_tready = 1'b0;
    case (state)
      BUSY: begin
        m_tvalid  = sel_tvalid;
        m_tlast   = sel_tlast | trunc_beat;
        s0_tready = ~owner & m_tready;
        s1_tready = owner & m_tready;
      end
      DRAIN: begin
        s0_tready = ~owner;
        s1_tready = owner;
      end
      default: ;
    endcase
  end

  always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
    if (!m_axi_aresetn) begin
      state       <= IDLE;
      grant       <= 2'b00;
      owner       <= 1'b0;
      last_served <= 1'b1;
      word_cnt    <= '0;
      gap_cnt     <= '0;
      frame_count <= '0;
      overlength  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s0_tvalid || s1_tvalid) begin
            owner    <= pick_s1;
            grant    <= pick_s1 ? 2'b10 : 2'b01;
            word_cnt <= '0;
            state    <= BUSY;
          end
        end

        BUSY: begin
          if (out_beat) begin
            if (sel_tlast) begin
              frame_count <= frame_count + 32'd1;
              last_served <= owner;
              word_cnt    <= '0;
              grant       <= 2'b00;
              gap_cnt     <= GAP_LOAD;
              state       <= (FRAME_GAP == 0) ? IDLE : GAP;
            end else if (trunc_beat) begin
              // Forced tlast went out on this beat; the frame counts as sent.
              frame_count <= frame_count + 32'd1;
              overlength  <= 1'b1;
              word_cnt    <= '0;
              state       <= DRAIN;
            end else begin
              word_cnt <= word_cnt + 1'b1;
            end
          end
        end

        DRAIN: begin
          if (sel_tvalid && sel_tlast) begin
            last_served <= owner;
            grant       <= 2'b00;
            gap_cnt     <= GAP_LOAD;
            state       <= (FRAME_GAP == 0) ? IDLE : GAP;
          end
        end

        GAP: begin
          // gap_cnt is loaded with FRAME_GAP-1 on entry, so GAP lasts
          // exactly FRAME_GAP cycles.
          if (gap_cnt == '0) begin
            state <= IDLE;
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_tx_arbiter.sv
// tb_eth_tx_arbiter
// Self-checking bench for eth_tx_arbiter (FRAME_GAP=2, MAX_FRAME_WORDS=4).
// A negedge monitor logs every output beat together with its owner. The
// source drivers push the beats they expect to see on m_* into per-source
// queues, and each scenario task checks the log against those queues.
module tb_eth_tx_arbiter;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        src;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg = 1'b0;
  logic [31:0] s0_tdata = '0, s1_tdata = '0;
  logic [3:0]  s0_tkeep = '0, s1_tkeep = '0;
  logic        s0_tvalid = 1'b0, s1_tvalid = 1'b0;
  logic        s0_tlast = 1'b0, s1_tlast = 1'b0;
  logic        s0_tready, s1_tready;
  logic [31:0] m_tdata;
  logic [3:0]  m_tkeep;
  logic        m_tvalid, m_tlast;
  logic        m_tready = 1'b0;
  logic [1:0]  grant;
  logic [31:0] frame_count;
  logic        overlength;

  beat_t obs_q[$];
  beat_t exp0_q[$];
  beat_t exp1_q[$];
  int    rd_idx = 0;
  int    tests_run = 0;
  int    fails = 0;
  int    timeouts = 0;
  bit    s0_done;
  bit    s1_rdy_seen;

  eth_tx_arbiter #(
    .DATA_WIDTH(32), .KEEP_WIDTH(4), .FRAME_GAP(2), .MAX_FRAME_WORDS(4)
  ) dut (
    .m_axi_aclk(clk), .m_axi_aresetn(rst_n), .cfg_fixed_prio(cfg),
    .s0_tdata(s0_tdata), .s0_tkeep(s0_tkeep), .s0_tvalid(s0_tvalid),
    .s0_tlast(s0_tlast), .s0_tready(s0_tready),
    .s1_tdata(s1_tdata), .s1_tkeep(s1_tkeep), .s1_tvalid(s1_tvalid),
    .s1_tlast(s1_tlast), .s1_tready(s1_tready),
    .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid),
    .m_tlast(m_tlast), .m_tready(m_tready),
    .grant(grant), .frame_count(frame_count), .overlength(overlength)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) obs_q.push_back({m_tdata, m_tkeep, m_tlast, grant[1]});
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
    $fatal(1, "watchdog");
  end

  task automatic drive(input bit src, input bit v, input logic [31:0] d, input logic [3:0] k, input bit l);
    if (src) begin
      s1_tvalid = v; s1_tdata = d; s1_tkeep = k; s1_tlast = l;
    end else begin
      s0_tvalid = v; s0_tdata = d; s0_tkeep = k; s0_tlast = l;
    end
  endtask

  // Sends one frame of nw words with AXI handshakes. Only the first keep_n
  // beats are expected on m_*; the last of those carries tlast.
  task automatic send(input bit src, input int nw, input logic [31:0] base, input int keep_n);
    logic [31:0] d;
    logic [3:0]  k;
    bit          l, hs;
    int          t;
    for (int i = 0; i < nw; i++) begin
      d = base + 32'(i);
      k = (i == nw - 1) ? 4'b0111 : 4'b1111;
      l = (i == nw - 1);
      drive(src, 1'b1, d, k, l);
      if (i < keep_n) begin
        if (src) exp1_q.push_back({d, k, l | (i == keep_n - 1), src});
        else     exp0_q.push_back({d, k, l | (i == keep_n - 1), src});
      end
      t = 0;
      do begin
        @(negedge clk);
        hs = src ? (s1_tvalid && s1_tready) : (s0_tvalid && s0_tready);
        @(posedge clk); #1;
        t++;
      end while (!hs && t < 100);
      if (!hs) timeouts++;
    end
    drive(src, 1'b0, '0, '0, 1'b0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    m_tready = 1'b1;
    drive(1'b0, 1'b1, 32'h1234_5678, 4'hF, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({grant, m_tvalid, m_tlast, s0_tready, s1_tready} !== 6'b0) begin
      fails++;
      $display("FAIL reset_outputs: grant/valid/last/rdy0/rdy1 = %b, required 000000",
               {grant, m_tvalid, m_tlast, s0_tready, s1_tready});
    end
    tests_run++;
    if (frame_count !== 32'd0 || overlength !== 1'b0) begin
      fails++;
      $display("FAIL reset_status: frame_count=%0d overlength=%b, required 0 0", frame_count, overlength);
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (grant !== 2'b00 || m_tvalid !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: grant=%b m_tvalid=%b, required 00 0", grant, m_tvalid);
    end
  endtask

  task automatic test_single();
    logic [1:0]  g [8];
    logic [1:0]  g_e [8] = '{2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
    logic [31:0] fc4;
    logic        v4;
    beat_t       ob, ex;
    apply_reset();
    cfg = 1'b0; m_tready = 1'b1;
    fork
      begin
        send(1'b0, 3, 32'hA000_0000, 3);
        send(1'b0, 3, 32'hA000_0010, 3);
      end
      begin
        for (int k = 0; k < 8; k++) begin
          @(negedge clk);
          g[k] = grant;
          if (k == 4) begin fc4 = frame_count; v4 = m_tvalid; end
        end
      end
    join
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (g[k] !== g_e[k]) begin
        fails++;
        $display("FAIL single_grant[%0d]: grant=%b, required %b", k, g[k], g_e[k]);
      end
    end
    tests_run++;
    if (fc4 !== 32'd1 || v4 !== 1'b0) begin
      fails++;
      $display("FAIL single_after_frame: frame_count=%0d m_tvalid=%b, required 1 0", fc4, v4);
    end
    tests_run++;
    if (frame_count !== 32'd2) begin
      fails++;
      $display("FAIL single_count: frame_count=%0d, required 2", frame_count);
    end
    while (rd_idx < obs_q.size()) begin
      ob = obs_q[rd_idx]; rd_idx++;
      ex = ~ob;
      if (ob.src && exp1_q.size() > 0) ex = exp1_q.pop_front();
      else if (!ob.src && exp0_q.size() > 0) ex = exp0_q.pop_front();
      tests_run++;
      if (ob !== ex) begin fails++; $display("FAIL single_beat: got %h, required %h", ob, ex); end
    end
    tests_run++;
    if (exp0_q.size() + exp1_q.size() != 0 || timeouts != 0) begin
      fails++;
      $display("FAIL single_missing: %0d beats unseen, %0d timeouts, required 0 0",
               exp0_q.size() + exp1_q.size(), timeouts);
    end
    exp0_q.delete(); exp1_q.delete(); timeouts = 0;
  endtask

  task automatic test_rr();
    int    start, contig_err;
    bit    own[$];
    bit    own_e [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    beat_t ob, ex;
    apply_reset();
    cfg = 1'b0; m_tready = 1'b1;
    start = obs_q.size();
    fork
      for (int f = 0; f < 3; f++) send(1'b0, 2, 32'hB000_0000 + 32'(f * 16), 2);
      for (int f = 0; f < 3; f++) send(1'b1, 2, 32'hC000_0000 + 32'(f * 16), 2);
    join
    contig_err = 0;
    for (int i = start; i < obs_q.size(); i++) begin
      if (obs_q[i].last) own.push_back(obs_q[i].src);
      if (i > start && !obs_q[i-1].last && obs_q[i].src != obs_q[i-1].src) contig_err++;
    end
    tests_run++;
    if (own.size() != 6 || contig_err != 0) begin
      fails++;
      $display("FAIL rr_frames: %0d frames, %0d interleaved beats, required 6 0", own.size(), contig_err);
    end
    for (int i = 0; i < 6 && i < own.size(); i++) begin
      tests_run++;
      if (own[i] !== own_e[i]) begin
        fails++;
        $display("FAIL rr_order[%0d]: source %0d, required %0d", i, own[i], own_e[i]);
      end
    end
    while (rd_idx < obs_q.size()) begin
      ob = obs_q[rd_idx]; rd_idx++;
      ex = ~ob;
      if (ob.src && exp1_q.size() > 0) ex = exp1_q.pop_front();
      else if (!ob.src && exp0_q.size() > 0) ex = exp0_q.pop_front();
      tests_run++;
      if (ob !== ex) begin fails++; $display("FAIL rr_beat: got %h, required %h", ob, ex); end
    end
    tests_run++;
    if (exp0_q.size() + exp1_q.size() != 0 || timeouts != 0) begin
      fails++;
      $display("FAIL rr_missing: %0d beats unseen, %0d timeouts, required 0 0",
               exp0_q.size() + exp1_q.size(), timeouts);
    end
    exp0_q.delete(); exp1_q.delete(); timeouts = 0;
  endtask

  task automatic test_fixed();
    int    start;
    bit    own[$];
    bit    own_e [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    apply_reset();
    cfg = 1'b1; m_tready = 1'b1;
    s0_done = 1'b0; s1_rdy_seen = 1'b0;
    start = obs_q.size();
    fork
      begin
        for (int f = 0; f < 3; f++) send(1'b0, 2, 32'hE000_0000 + 32'(f * 16), 2);
        s0_done = 1'b1;
      end
      send(1'b1, 2, 32'hF000_0000, 2);
      begin
        while (!s0_done) begin
          @(negedge clk);
          if (!s0_done && s1_tready) s1_rdy_seen = 1'b1;
        end
      end
    join
    cfg = 1'b0;
    for (int i = start; i < obs_q.size(); i++) if (obs_q[i].last) own.push_back(obs_q[i].src);
    tests_run++;
    if (s1_rdy_seen !== 1'b0) begin
      fails++;
      $display("FAIL fixed_starve: s1_tready seen=%b while s0 requesting, required 0", s1_rdy_seen);
    end
    tests_run++;
    if (own.size() != 4) begin
      fails++;
      $display("FAIL fixed_frames: %0d frames, required 4", own.size());
    end
    for (int i = 0; i < 4 && i < own.size(); i++) begin
      tests_run++;
      if (own[i] !== own_e[i]) begin
        fails++;
        $display("FAIL fixed_order[%0d]: source %0d, required %0d", i, own[i], own_e[i]);
      end
    end
    rd_idx = obs_q.size();
    tests_run++;
    if (timeouts != 0) begin
      fails++;
      $display("FAIL fixed_timeout: %0d timeouts, required 0", timeouts);
    end
    exp0_q.delete(); exp1_q.delete(); timeouts = 0;
  endtask

  task automatic test_backpressure();
    bit    pat [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    beat_t ob, ex;
    apply_reset();
    cfg = 1'b0; m_tready = 1'b1;
    fork
      send(1'b1, 4, 32'hD000_0000, 4);
      begin
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (grant !== 2'b10 || s1_tready !== 1'b1) begin
          fails++;
          $display("FAIL bp_grant: grant=%b s1_tready=%b, required 10 1", grant, s1_tready);
        end
        for (int i = 0; i < 5; i++) begin
          @(posedge clk); #1;
          m_tready = pat[i];
          @(negedge clk);
          tests_run++;
          if (grant !== 2'b10 || s1_tready !== m_tready || s0_tready !== 1'b0) begin
            fails++;
            $display("FAIL bp_hold[%0d]: grant=%b s1_tready=%b s0_tready=%b, required 10 %b 0",
                     i, grant, s1_tready, s0_tready, m_tready);
          end
        end
        @(posedge clk); #1;
        @(negedge clk);
        tests_run++;
        if (grant !== 2'b00) begin
          fails++;
          $display("FAIL bp_release: grant=%b, required 00", grant);
        end
      end
    join
    m_tready = 1'b1;
    while (rd_idx < obs_q.size()) begin
      ob = obs_q[rd_idx]; rd_idx++;
      ex = ~ob;
      if (ob.src && exp1_q.size() > 0) ex = exp1_q.pop_front();
      else if (!ob.src && exp0_q.size() > 0) ex = exp0_q.pop_front();
      tests_run++;
      if (ob !== ex) begin fails++; $display("FAIL bp_beat: got %h, required %h", ob, ex); end
    end
    tests_run++;
    if (exp0_q.size() + exp1_q.size() != 0 || timeouts != 0) begin
      fails++;
      $display("FAIL bp_missing: %0d beats unseen, %0d timeouts, required 0 0",
               exp0_q.size() + exp1_q.size(), timeouts);
    end
    exp0_q.delete(); exp1_q.delete(); timeouts = 0;
  endtask

  task automatic test_truncation();
    // Per sample: {grant, m_tvalid, m_tlast, s0_tready}
    logic [4:0] s [12];
    logic [4:0] s_e [12] = '{5'b00000, 5'b01101, 5'b01101, 5'b01101, 5'b01111, 5'b01001,
                             5'b01001, 5'b01001, 5'b00000, 5'b00000, 5'b00000, 5'b01111};
    logic       ov4, ov5;
    logic [31:0] fc5;
    beat_t      ob, ex;
    apply_reset();
    cfg = 1'b0; m_tready = 1'b1;
    fork
      begin
        send(1'b0, 7, 32'h7000_0000, 4);
        send(1'b0, 1, 32'h7100_0000, 1);
      end
      begin
        for (int k = 0; k < 12; k++) begin
          @(negedge clk);
          s[k] = {grant, m_tvalid, m_tlast, s0_tready};
          if (k == 4) ov4 = overlength;
          if (k == 5) begin ov5 = overlength; fc5 = frame_count; end
        end
      end
    join
    for (int k = 0; k < 12; k++) begin
      tests_run++;
      if (s[k] !== s_e[k]) begin
        fails++;
        $display("FAIL trunc_cycle[%0d]: grant,valid,last,rdy=%b, required %b", k, s[k], s_e[k]);
      end
    end
    tests_run++;
    if (ov4 !== 1'b0 || ov5 !== 1'b1 || fc5 !== 32'd1) begin
      fails++;
      $display("FAIL trunc_status: overlength before/after=%b/%b frame_count=%0d, required 0/1 1",
               ov4, ov5, fc5);
    end
    while (rd_idx < obs_q.size()) begin
      ob = obs_q[rd_idx]; rd_idx++;
      ex = ~ob;
      if (ob.src && exp1_q.size() > 0) ex = exp1_q.pop_front();
      else if (!ob.src && exp0_q.size() > 0) ex = exp0_q.pop_front();
      tests_run++;
      if (ob !== ex) begin fails++; $display("FAIL trunc_beat: got %h, required %h", ob, ex); end
    end
    tests_run++;
    if (exp0_q.size() + exp1_q.size() != 0 || timeouts != 0) begin
      fails++;
      $display("FAIL trunc_missing: %0d beats unseen, %0d timeouts, required 0 0",
               exp0_q.size() + exp1_q.size(), timeouts);
    end
    exp0_q.delete(); exp1_q.delete(); timeouts = 0;
  endtask

  task automatic test_reset_mid();
    int    t;
    beat_t ob, ex;
    m_tready = 1'b1;
    drive(1'b0, 1'b1, 32'h5000_0000, 4'hF, 1'b0);
    exp0_q.push_back({32'h5000_0000, 4'hF, 1'b0, 1'b0});
    t = 0;
    while (grant !== 2'b01 && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    tests_run++;
    if (grant !== 2'b01) begin
      fails++;
      $display("FAIL rstmid_grant: grant=%b after %0d cycles, required 01", grant, t);
    end
    @(negedge clk);
    @(posedge clk); #1;
    drive(1'b0, 1'b1, 32'h5000_0001, 4'hF, 1'b0);
    #1;
    tests_run++;
    if (m_tvalid !== 1'b1 || frame_count !== 32'd2 || overlength !== 1'b1) begin
      fails++;
      $display("FAIL rstmid_before: m_tvalid=%b frame_count=%0d overlength=%b, required 1 2 1",
               m_tvalid, frame_count, overlength);
    end
    #1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({m_tvalid, grant, s0_tready, overlength} !== 5'b0 || frame_count !== 32'd0) begin
      fails++;
      $display("FAIL rstmid_async: valid,grant,rdy,ovl=%b frame_count=%0d, required 00000 0",
               {m_tvalid, grant, s0_tready, overlength}, frame_count);
    end
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    while (rd_idx < obs_q.size()) begin
      ob = obs_q[rd_idx]; rd_idx++;
      ex = ~ob;
      if (ob.src && exp1_q.size() > 0) ex = exp1_q.pop_front();
      else if (!ob.src && exp0_q.size() > 0) ex = exp0_q.pop_front();
      tests_run++;
      if (ob !== ex) begin fails++; $display("FAIL rstmid_beat: got %h, required %h", ob, ex); end
    end
    tests_run++;
    if (exp0_q.size() + exp1_q.size() != 0) begin
      fails++;
      $display("FAIL rstmid_missing: %0d beats unseen, required 0", exp0_q.size() + exp1_q.size());
    end
    exp0_q.delete(); exp1_q.delete();
  endtask

  initial begin
    test_reset();
    test_single();
    test_rr();
    test_fixed();
    test_backpressure();
    test_truncation();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
